// File: rtl/traffic_light_ctrl_param.sv
// Parametrised N-approach round-robin traffic light controller with sensor-based skipping.
// Optional emergency pre-emption is built in when TLC_EMERGENCY_PREEMPT_EN is defined.
module traffic_light_ctrl_param #(
    parameter  int unsigned NUM_DIR    = 4,
    parameter  int unsigned GREEN_CYC  = 8,
    parameter  int unsigned YELLOW_CYC = 3,
    parameter  int unsigned ALLRED_CYC = 1,
    parameter  int unsigned CNT_W      = 4,
    localparam int unsigned DIR_W      = $clog2(NUM_DIR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_DIR-1:0]     sensor,
`ifdef TLC_EMERGENCY_PREEMPT_EN
    input  logic                   emerg_req,
    input  logic [DIR_W-1:0]       emerg_dir,
`endif
    output logic [3*NUM_DIR-1:0]   lights,
    output logic [1:0]             phase,
    output logic [DIR_W-1:0]       cur_dir,
    output logic [CNT_W-1:0]       count
);

    localparam int unsigned SUM_W = DIR_W + 1;

    localparam logic [CNT_W-1:0]     G_LOAD   = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0]     Y_LOAD   = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0]     A_LOAD   = CNT_W'(ALLRED_CYC - 1);
    localparam logic [DIR_W-1:0]     LAST_DIR = DIR_W'(NUM_DIR - 1);
    localparam logic [3*NUM_DIR-1:0] ALL_RED  = {NUM_DIR{3'b100}};

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    phase_e                 state_q, state_d;
    logic [DIR_W-1:0]       dir_q, dir_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3*NUM_DIR-1:0]   lights_q, lights_d;

    logic                   em_req;
    logic [DIR_W-1:0]       em_dir;
    logic                   em_ok;

`ifdef TLC_EMERGENCY_PREEMPT_EN
    assign em_req = emerg_req;
    assign em_dir = emerg_dir;
`else
    assign em_req = 1'b0;
    assign em_dir = '0;
`endif

    // Emergency target only honoured when it names a real approach.
    assign em_ok = (SUM_W'(em_dir) < SUM_W'(NUM_DIR));

    // Sensors rotated so bit j is approach (cur_dir+1+j) mod NUM_DIR; cur_dir lands last.
    logic [SUM_W-1:0]   shamt;
    logic [NUM_DIR-1:0] rot;
    logic [DIR_W-1:0]   off;
    logic [SUM_W-1:0]   sum;
    logic [DIR_W-1:0]   scan_next;

    assign shamt = SUM_W'(dir_q) + SUM_W'(1);
    assign rot   = NUM_DIR'({sensor, sensor} >> shamt);

    always_comb begin
        off = '0;
        for (int j = NUM_DIR - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = DIR_W'(j);
            end
        end
    end

    // off stays 0 with no sensors, giving the fixed-time advance by one.
    assign sum       = SUM_W'(dir_q) + SUM_W'(off) + SUM_W'(1);
    assign scan_next = (sum >= SUM_W'(NUM_DIR)) ? DIR_W'(sum - SUM_W'(NUM_DIR))
                                                : DIR_W'(sum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= PH_ALLRED;
            dir_q    <= LAST_DIR;
            cnt_q    <= A_LOAD;
            lights_q <= ALL_RED;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            lights_q <= lights_d;
        end
    end

    // Next-state, counter and lamp pattern; lamps derive from the next state so they move with phase.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q - CNT_W'(1);
        case (state_q)
            PH_GREEN: begin
                if (em_req && (em_dir == dir_q)) begin
                    cnt_d = cnt_q;
                end else if (em_req || (cnt_q == '0)) begin
                    state_d = PH_YELLOW;
                    cnt_d   = Y_LOAD;
                end
            end
            PH_YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = PH_ALLRED;
                    cnt_d   = A_LOAD;
                end
            end
            PH_ALLRED: begin
                if (cnt_q == '0) begin
                    state_d = PH_GREEN;
                    cnt_d   = G_LOAD;
                    dir_d   = (em_req && em_ok) ? em_dir : scan_next;
                end
            end
            default: begin
                state_d = PH_ALLRED;
                cnt_d   = A_LOAD;
            end
        endcase

        lights_d = ALL_RED;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (DIR_W'(i) == dir_d) begin
                if (state_d == PH_GREEN) begin
                    lights_d[3*i +: 3] = 3'b001;
                end else if (state_d == PH_YELLOW) begin
                    lights_d[3*i +: 3] = 3'b010;
                end
            end
        end
    end

    assign lights  = lights_q;
    assign phase   = state_q;
    assign cur_dir = dir_q;
    assign count   = cnt_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Bench for traffic_light_ctrl_param: default 4-way instance and a 3-way parameter sweep,
// each checked every cycle against a behavioural model through expectation queues.
module tb_traffic_light_ctrl_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sens_a;
    logic [2:0]  sens_b;
    logic [11:0] lights_a;
    logic [1:0]  phase_a;
    logic [1:0]  dir_a;
    logic [3:0]  count_a;
    logic [8:0]  lights_b;
    logic [1:0]  phase_b;
    logic [1:0]  dir_b;
    logic [3:0]  count_b;
`ifdef TLC_EMERGENCY_PREEMPT_EN
    logic        em_req;
    logic [1:0]  em_dir;
`endif

    always #5 clk = ~clk;

    traffic_light_ctrl_param u_dut_a (
        .clk     (clk),
        .rst     (rst),
        .sensor  (sens_a),
`ifdef TLC_EMERGENCY_PREEMPT_EN
        .emerg_req (em_req),
        .emerg_dir (em_dir),
`endif
        .lights  (lights_a),
        .phase   (phase_a),
        .cur_dir (dir_a),
        .count   (count_a)
    );

    traffic_light_ctrl_param #(
        .NUM_DIR    (3),
        .GREEN_CYC  (5),
        .YELLOW_CYC (2),
        .ALLRED_CYC (2),
        .CNT_W      (4)
    ) u_dut_b (
        .clk     (clk),
        .rst     (rst),
        .sensor  (sens_b),
`ifdef TLC_EMERGENCY_PREEMPT_EN
        .emerg_req (1'b0),
        .emerg_dir (2'd0),
`endif
        .lights  (lights_b),
        .phase   (phase_b),
        .cur_dir (dir_b),
        .count   (count_b)
    );

    typedef struct {
        int ph;
        int dir;
        int cnt;
    } st_t;

    st_t ma, mb;
    st_t qa[$];
    st_t qb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc;
    int  prev_pa, prev_pb;
    int  first_a, second_a, first_b, second_b;
    bit  er_now;
    int  ed_now;
    bit  found;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Behavioural model: one clock of the controller.
    function automatic st_t step(st_t s, int nd, int g, int y, int a,
                                 logic [7:0] sens, bit er, int ed);
        st_t r;
        int  nxt;
        r = s;
        if (s.ph == 0) begin
            if (er && s.dir == ed) r.cnt = s.cnt;
            else if (er || s.cnt == 0) begin r.ph = 1; r.cnt = y - 1; end
            else r.cnt = s.cnt - 1;
        end else if (s.ph == 1) begin
            if (s.cnt == 0) begin r.ph = 2; r.cnt = a - 1; end
            else r.cnt = s.cnt - 1;
        end else begin
            if (s.cnt == 0) begin
                nxt = (s.dir + 1) % nd;
                for (int k = nd; k >= 1; k--)
                    if (sens[(s.dir + k) % nd]) nxt = (s.dir + k) % nd;
                if (er) nxt = ed;
                r.ph = 0; r.cnt = g - 1; r.dir = nxt;
            end else r.cnt = s.cnt - 1;
        end
        return r;
    endfunction

    function automatic logic [23:0] lamp(st_t s, int nd);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            if (i == s.dir && s.ph == 0)      r[3*i +: 3] = 3'b001;
            else if (i == s.dir && s.ph == 1) r[3*i +: 3] = 3'b010;
            else                              r[3*i +: 3] = 3'b100;
        end
        return r;
    endfunction

    // Called at a falling edge: push expectations, clock once, compare, return at next falling edge.
    task automatic tick();
        st_t ga, gb;
`ifdef TLC_EMERGENCY_PREEMPT_EN
        er_now = em_req;
        ed_now = int'(em_dir);
`endif
        ma = step(ma, 4, 8, 3, 1, 8'(sens_a), er_now, ed_now);
        qa.push_back(ma);
        mb = step(mb, 3, 5, 2, 2, 8'(sens_b), 1'b0, 0);
        qb.push_back(mb);
        @(posedge clk);
        #1;
        cyc++;
        ga = qa.pop_front();
        gb = qb.pop_front();
        check("phase_a",  32'(phase_a),  32'(ga.ph));
        check("dir_a",    32'(dir_a),    32'(ga.dir));
        check("count_a",  32'(count_a),  32'(ga.cnt));
        check("lights_a", 32'(lights_a), 32'(lamp(ga, 4)));
        check("phase_b",  32'(phase_b),  32'(gb.ph));
        check("dir_b",    32'(dir_b),    32'(gb.dir));
        check("count_b",  32'(count_b),  32'(gb.cnt));
        check("lights_b", 32'(lights_b), 32'(lamp(gb, 3)));
        if (phase_a == 2'b00 && prev_pa != 0 && dir_a == 2'd0) begin
            if (first_a < 0) first_a = cyc;
            else if (second_a < 0) second_a = cyc;
        end
        if (phase_b == 2'b00 && prev_pb != 0 && dir_b == 2'd0) begin
            if (first_b < 0) first_b = cyc;
            else if (second_b < 0) second_b = cyc;
        end
        prev_pa = int'(phase_a);
        prev_pb = int'(phase_b);
        @(negedge clk);
    endtask

    // Asserts reset (asynchronously), checks reset values, releases at the next falling edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_phase_a",  32'(phase_a),  32'd2);
        check("rst_dir_a",    32'(dir_a),    32'd3);
        check("rst_count_a",  32'(count_a),  32'd0);
        check("rst_lights_a", 32'(lights_a), 32'h924);
        check("rst_phase_b",  32'(phase_b),  32'd2);
        check("rst_dir_b",    32'(dir_b),    32'd2);
        check("rst_count_b",  32'(count_b),  32'd1);
        check("rst_lights_b", 32'(lights_b), 32'h124);
        ma = '{2, 3, 0};
        mb = '{2, 2, 1};
        prev_pa = 2; prev_pb = 2;
        first_a = -1; second_a = -1; first_b = -1; second_b = -1;
        cyc = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        sens_a = '0;
        sens_b = '0;
        er_now = 1'b0;
        ed_now = 0;
`ifdef TLC_EMERGENCY_PREEMPT_EN
        em_req = 1'b0;
        em_dir = 2'd0;
`endif
        repeat (2) @(negedge clk);
        do_reset();

        // Fixed-time rotation with no sensors.
        repeat (100) tick();
        check("first_green_a", 32'(first_a), 32'd1);
        check("rotation_a",    32'(second_a - first_a), 32'd48);

        // Only approach 3 requests: it is served repeatedly.
        sens_a = 4'b1000;
        repeat (60) tick();
        check("skip_dir",  32'(dir_a), 32'd3);
        check("skip_red",  32'(lights_a[8:0]), 32'h124);

        // Round-robin scan with sensor glitches outside the final all-red cycle.
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ma.ph == 2 && ma.cnt == 0 && ma.dir == 1) begin found = 1'b1; break; end
            sens_a = (ma.ph == 2 && ma.cnt == 0) ? 4'b0000 : 4'($urandom);
            tick();
        end
        check("reach_dir1", 32'(found), 32'd1);
        sens_a = 4'b0101;
        tick();
        check("scan_to_2", 32'(dir_a), 32'd2);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ma.ph == 2 && ma.cnt == 0) begin found = 1'b1; break; end
            sens_a = 4'($urandom);
            tick();
        end
        check("reach_dir2_clr", 32'(found), 32'd1);
        sens_a = 4'b0001;
        tick();
        check("scan_to_0", 32'(dir_a), 32'd0);

        // Mid-green reset at count 3, then the sequence restarts.
        sens_a = 4'b0000;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ma.ph == 0 && ma.cnt == 3) begin found = 1'b1; break; end
            tick();
        end
        check("reach_green3", 32'(found), 32'd1);
        do_reset();
        repeat (60) tick();
        check("restart_green_a", 32'(first_a), 32'd1);
        check("first_green_b",   32'(first_b), 32'd2);
        check("rotation_b",      32'(second_b - first_b), 32'd27);

`ifdef TLC_EMERGENCY_PREEMPT_EN
        // Pre-emption toward approach 2 during approach 0 green, then release.
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ma.ph == 0 && ma.dir == 0 && ma.cnt >= 4) begin found = 1'b1; break; end
            tick();
        end
        check("reach_green0", 32'(found), 32'd1);
        em_req = 1'b1;
        em_dir = 2'd2;
        repeat (30) tick();
        check("emerg_phase", 32'(phase_a), 32'd0);
        check("emerg_dir",   32'(dir_a),   32'd2);
        em_req = 1'b0;
        repeat (30) tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
